// File: rtl/map_window_sequencer.sv
// Sliding-window MAP sequencer: loads a block, then steps gamma, alpha, dummy-beta and beta/LLR phases window by window.
// Optional MAP_WIN_STALL_EN adds a stall input that freezes the compute phases.
module map_window_sequencer #(
    parameter int BLK_LEN = 6144,
    parameter int WIN_LEN = 32,
    parameter int ADDR_W  = 13,
    parameter int WADDR_W = 5
) (
    input  logic               clk,
    input  logic               reset_n,
`ifdef MAP_WIN_STALL_EN
    input  logic               stall,
`endif
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               in_wr_en,
    output logic [ADDR_W-1:0]  blk_addr,
    output logic [WADDR_W-1:0] win_addr,
    output logic               gamma_en,
    output logic               alpha_en,
    output logic               dummy_en,
    output logic               beta_en,
    output logic               beta_init,
    output logic               beta_term,
    output logic               llr_valid,
    output logic               busy,
    output logic               done
);

    localparam int NW = BLK_LEN / WIN_LEN;
    localparam logic [ADDR_W-1:0]  BLK_LAST   = ADDR_W'(BLK_LEN - 1);
    localparam logic [ADDR_W-1:0]  W_LAST     = ADDR_W'(NW - 1);
    localparam logic [ADDR_W-1:0]  WIN_A      = ADDR_W'(WIN_LEN);
    localparam logic [ADDR_W-1:0]  WIN2_A     = ADDR_W'(2 * WIN_LEN);
    localparam logic [ADDR_W-1:0]  ONE_A      = ADDR_W'(1);
    localparam logic [WADDR_W-1:0] WIN_LAST_I = WADDR_W'(WIN_LEN - 1);
    localparam logic [WADDR_W-1:0] ONE_I      = WADDR_W'(1);

    if ((BLK_LEN % WIN_LEN) != 0) begin : g_chk_blk
        $error("BLK_LEN must be a multiple of WIN_LEN");
    end
    if (WIN_LEN < 2) begin : g_chk_win
        $error("WIN_LEN must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_GAMMA, S_ALPHA, S_DUMMY, S_BETA, S_DONE
    } state_t;

    state_t               r_state, w_state_nx;
    logic [ADDR_W-1:0]    r_cnt, w_cnt_nx;
    logic [WADDR_W-1:0]   r_i, w_i_nx;
    logic [ADDR_W-1:0]    r_w, w_w_nx;
    logic [ADDR_W-1:0]    w_base, w_i_ext;
    logic                 w_stall;

    logic [ADDR_W-1:0]    r_blk_addr, w_blk_nx;
    logic [WADDR_W-1:0]   r_win_addr, w_win_nx;
    logic r_in_ready, r_gamma_en, r_alpha_en, r_dummy_en, r_beta_en;
    logic r_beta_init, r_beta_term, r_busy, r_done;
    logic w_in_ready_nx, w_gamma_nx, w_alpha_nx, w_dummy_nx, w_beta_nx;
    logic w_init_nx, w_term_nx, w_busy_nx, w_done_nx;

    // Stall only bites in the compute phases; IDLE, LOAD and DONE run regardless.
`ifdef MAP_WIN_STALL_EN
    assign w_stall = stall && (r_state == S_GAMMA || r_state == S_ALPHA ||
                               r_state == S_DUMMY || r_state == S_BETA);
`else
    assign w_stall = 1'b0;
`endif

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_i_nx     = r_i;
        w_w_nx     = r_w;
        unique case (r_state)
            S_IDLE: if (start) begin
                w_state_nx = S_LOAD;
                w_cnt_nx   = '0;
            end
            S_LOAD: if (in_valid) begin
                if (r_cnt == BLK_LAST) begin
                    w_state_nx = S_GAMMA;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + ONE_A;
                end
            end
            S_GAMMA: if (!w_stall) begin
                if (r_cnt == BLK_LAST) begin
                    w_state_nx = S_ALPHA;
                    w_cnt_nx   = '0;
                    w_i_nx     = '0;
                    w_w_nx     = '0;
                end else begin
                    w_cnt_nx = r_cnt + ONE_A;
                end
            end
            S_ALPHA: if (!w_stall) begin
                if (r_i == WIN_LAST_I) begin
                    w_i_nx     = '0;
                    w_state_nx = (r_w == W_LAST) ? S_BETA : S_DUMMY;
                end else begin
                    w_i_nx = r_i + ONE_I;
                end
            end
            S_DUMMY: if (!w_stall) begin
                if (r_i == WIN_LAST_I) begin
                    w_i_nx     = '0;
                    w_state_nx = S_BETA;
                end else begin
                    w_i_nx = r_i + ONE_I;
                end
            end
            S_BETA: if (!w_stall) begin
                if (r_i == WIN_LAST_I) begin
                    w_i_nx = '0;
                    if (r_w == W_LAST) begin
                        w_state_nx = S_DONE;
                    end else begin
                        w_w_nx     = r_w + ONE_A;
                        w_state_nx = S_ALPHA;
                    end
                end else begin
                    w_i_nx = r_i + ONE_I;
                end
            end
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Output values are derived from the next state so the registers line up with the state they describe.
    assign w_base  = w_w_nx * WIN_A;
    assign w_i_ext = ADDR_W'(w_i_nx);

    always_comb begin
        w_blk_nx      = '0;
        w_win_nx      = '0;
        w_in_ready_nx = 1'b0;
        w_gamma_nx    = 1'b0;
        w_alpha_nx    = 1'b0;
        w_dummy_nx    = 1'b0;
        w_beta_nx     = 1'b0;
        w_init_nx     = 1'b0;
        w_term_nx     = 1'b0;
        w_busy_nx     = (w_state_nx != S_IDLE);
        w_done_nx     = (w_state_nx == S_DONE);
        case (w_state_nx)
            S_LOAD: begin
                w_in_ready_nx = 1'b1;
                w_blk_nx      = w_cnt_nx;
            end
            S_GAMMA: begin
                w_gamma_nx = 1'b1;
                w_blk_nx   = w_cnt_nx;
            end
            S_ALPHA: begin
                w_alpha_nx = 1'b1;
                w_blk_nx   = w_base + w_i_ext;
                w_win_nx   = w_i_nx;
            end
            S_DUMMY: begin
                w_dummy_nx = 1'b1;
                w_blk_nx   = w_base + WIN2_A - ONE_A - w_i_ext;
            end
            S_BETA: begin
                w_beta_nx = 1'b1;
                w_blk_nx  = w_base + WIN_A - ONE_A - w_i_ext;
                w_win_nx  = WIN_LAST_I - w_i_nx;
                w_init_nx = (w_i_nx == '0);
                w_term_nx = (w_i_nx == '0) && (w_w_nx == W_LAST);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_i         <= '0;
            r_w         <= '0;
            r_blk_addr  <= '0;
            r_win_addr  <= '0;
            r_in_ready  <= 1'b0;
            r_gamma_en  <= 1'b0;
            r_alpha_en  <= 1'b0;
            r_dummy_en  <= 1'b0;
            r_beta_en   <= 1'b0;
            r_beta_init <= 1'b0;
            r_beta_term <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_i         <= w_i_nx;
            r_w         <= w_w_nx;
            r_blk_addr  <= w_blk_nx;
            r_win_addr  <= w_win_nx;
            r_in_ready  <= w_in_ready_nx;
            r_gamma_en  <= w_gamma_nx;
            r_alpha_en  <= w_alpha_nx;
            r_dummy_en  <= w_dummy_nx;
            r_beta_en   <= w_beta_nx;
            r_beta_init <= w_init_nx;
            r_beta_term <= w_term_nx;
            r_busy      <= w_busy_nx;
            r_done      <= w_done_nx;
        end
    end

    // A held beta_init stays registered through a stall and reappears once the stall lifts.
    assign in_ready  = r_in_ready;
    assign in_wr_en  = in_valid & r_in_ready;
    assign blk_addr  = r_blk_addr;
    assign win_addr  = r_win_addr;
    assign gamma_en  = r_gamma_en & ~w_stall;
    assign alpha_en  = r_alpha_en & ~w_stall;
    assign dummy_en  = r_dummy_en & ~w_stall;
    assign beta_en   = r_beta_en & ~w_stall;
    assign beta_init = r_beta_init & ~w_stall;
    assign beta_term = r_beta_term;
    assign llr_valid = r_beta_en & ~w_stall;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
